uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Receive datapath of the UART, sitting between the baud clock generator and the UART register block.
- Consumes the 16x oversampling strobe (rx_sample_pulse) and the serial RX line.
- Deframes start/data/parity/stop bits into a one-entry holding register.
- Reports rx_ready, parity_err, framing_err and overflow to the register block; a register read of the RX data clears them.

Parameters:
SYNC_STAGES, 2, number of flops in the RX input synchronizer (>=2).

Ports:
PCLK  input  1  system clock.
PRESET  input  1  synchronous active-high reset.
rx_sample_pulse  input  1  one-PCLK strobe, 16 per bit period.
RX  input  1  asynchronous serial input; idle high.
data_bits  input  1  0 = 7 data bits, 1 = 8 data bits.
parity_en  input  1  1 = a parity bit follows the data.
parity_odd0_even1  input  1  parity sense: 0 = odd, 1 = even.
rx_data_reg_rd  input  1  one-cycle pulse on a register read of RX data.
rx_data  output  8  last accepted byte, LSB received first.
rx_ready  output  1  rx_data holds an unread byte.
parity_err  output  1  parity mismatch on the byte in rx_data.
framing_err  output  1  stop bit sampled low on the byte in rx_data.
overflow  output  1  a frame completed while rx_ready=1 (sticky).
rx_busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - Outputs: rx_data=0, rx_ready=0, parity_err=0, framing_err=0, overflow=0, rx_busy=0.
  - Internal: FSM=IDLE, tick counter=0, synchronizer flops=1.
  - Reset mid-frame aborts the frame; nothing is stored.
- All logic is clocked on PCLK. The counter and sampling advance only on cycles with rx_sample_pulse=1.
- rxs = last synchronizer stage.
- FSM states:
  - IDLE -> START: rxs=0 while previous rxs=1 (falling edge), evaluated every PCLK regardless of rx_sample_pulse. On entry, cnt=0 and data_bits/parity_en/parity_odd0_even1 are latched. Config changes mid-frame have no effect.
  - Bit sampling (every state except IDLE): 4-bit cnt increments on each pulse. rxs is captured on pulses with cnt=7, 8 and 9. Bit value = majority of the 3 captures.
  - START: on the pulse with cnt=15, go to IDLE if the bit value is 1 (false start, no flags change); otherwise go to DATA with bit index 0.
  - DATA: on the pulse with cnt=15, shift the bit in LSB-first.
    - After 7 or 8 bits (per the latched data_bits), go to PARITY if parity is enabled, else STOP.
    - In 7-bit mode rx_data[7]=0.
  - PARITY: on the pulse with cnt=15, capture the bit and go to STOP.
    - Even: the XOR of the data bits and the parity bit must be 0.
    - Odd: that XOR must be 1.
    - Mismatch -> pending parity_err=1.
    - With parity disabled, pending parity_err=0.
  - STOP: commit the frame on the pulse with cnt=9 (early, to allow back-to-back frames), then go to IDLE. Bit value 0 -> pending framing_err=1.
- Commit, in the PCLK edge where STOP exits:
  - Case rx_ready=0, or rx_data_reg_rd=1 in the same cycle: load rx_data, parity_err and framing_err; set rx_ready=1. overflow is unchanged, except that a same-cycle read clears it.
  - Case rx_ready=1 and no read in that cycle: set overflow=1. Discard the new frame; rx_data and all flags keep their old values.
- Read (rx_data_reg_rd=1, no commit in the same cycle): next edge clears rx_ready, parity_err, framing_err and overflow. rx_data holds its value.
- Line held low (break):
  - The frame completes with framing_err=1.
  - IDLE then requires a rising and then a falling edge before the next START.
- rx_busy=1 in every state except IDLE.
- Latency: rx_ready rises 1 PCLK after the commit pulse. That is ~9.6 bit periods (8N1) after the start edge, plus synchronizer delay.

Test Plan:
- 8N1, rx_sample_pulse every 4 PCLK; send 0x55 -> rx_data=0x55, rx_ready=1, parity_err=0, framing_err=0, overflow=0. Then pulse rx_data_reg_rd -> rx_ready=0 next cycle, rx_data still 0x55.
- 7E1, send 0x41 with correct parity bit 0 -> rx_data=0x41, parity_err=0. Resend with the parity bit flipped -> parity_err=1, rx_ready=1.
- 8O1 with a wrong parity bit, then 8N1 with a stop bit driven low, sending 0xA3 -> parity_err=1 on the first frame. framing_err=1 and rx_data=0xA3 on the second, after reading the first.
- Two back-to-back frames 0x12 then 0x34 without a read -> rx_data=0x12, overflow=1, rx_ready=1. A read clears overflow and rx_ready.
- A 5-sample low glitch on an idle line -> no rx_ready, rx_busy returns to 0 after 16 samples. Assert PRESET mid-frame -> all outputs 0; the next full frame 0xC3 is received correctly.
- rx_data_reg_rd asserted in the exact commit cycle of frame 0x7E while rx_ready=1 -> rx_data=0x7E, rx_ready=1, overflow=0.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receive deframer: 16x oversampled start/data/parity/stop into a one-entry holding register
module uart_rx_deframer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       rx_sample_pulse,
   input  logic       RX,
   input  logic       data_bits,
   input  logic       parity_en,
   input  logic       parity_odd0_even1,
   input  logic       rx_data_reg_rd,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overflow,
   output logic       rx_busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   rxs;
   logic                   rxs_q;
   logic [3:0]             cnt;
   logic [1:0]             samp;
   logic                   samp9;
   logic [2:0]             bit_idx;
   logic [7:0]             shreg;
   logic                   cfg_8;
   logic                   cfg_par;
   logic                   cfg_even;
   logic                   par_err_pend;
   logic                   bit_val;
   logic                   stop_val;
   logic                   last_data_bit;
   logic                   commit;
   logic                   accept;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         sync <= '1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], RX};
      end
   end

   assign rxs = sync[SYNC_STAGES-1];

   // The stop bit is judged at cnt=9, so its third vote is the live sample.
   assign bit_val       = (samp[0] & samp[1]) | (samp[0] & samp9) | (samp[1] & samp9);
   assign stop_val      = (samp[0] & samp[1]) | (samp[0] & rxs)   | (samp[1] & rxs);
   assign last_data_bit = (bit_idx == (cfg_8 ? 3'd7 : 3'd6));
   assign commit        = rx_sample_pulse && (state == STOP) && (cnt == 4'd9);
   assign accept        = !rx_ready || rx_data_reg_rd;
   assign rx_busy       = (state != IDLE);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state        <= IDLE;
         rxs_q        <= 1'b1;
         cnt          <= 4'd0;
         samp         <= 2'b11;
         samp9        <= 1'b1;
         bit_idx      <= 3'd0;
         shreg        <= 8'h00;
         cfg_8        <= 1'b1;
         cfg_par      <= 1'b0;
         cfg_even     <= 1'b0;
         par_err_pend <= 1'b0;
         rx_data      <= 8'h00;
         rx_ready     <= 1'b0;
         parity_err   <= 1'b0;
         framing_err  <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         rxs_q <= rxs;

         // Edge-only start detection also makes a held-low line rise before re-arming.
         if (state == IDLE) begin
            if (!rxs && rxs_q) begin
               state        <= START;
               cnt          <= 4'd0;
               bit_idx      <= 3'd0;
               shreg        <= 8'h00;
               par_err_pend <= 1'b0;
               cfg_8        <= data_bits;
               cfg_par      <= parity_en;
               cfg_even     <= parity_odd0_even1;
            end
         end else if (rx_sample_pulse) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) samp[0] <= rxs;
            if (cnt == 4'd8) samp[1] <= rxs;
            if (cnt == 4'd9) samp9   <= rxs;

            case (state)
               START: begin
                  if (cnt == 4'd15) begin
                     state <= bit_val ? IDLE : DATA;
                  end
               end
               DATA: begin
                  if (cnt == 4'd15) begin
                     shreg[bit_idx] <= bit_val;
                     bit_idx        <= bit_idx + 3'd1;
                     if (last_data_bit) begin
                        state <= cfg_par ? PARITY : STOP;
                     end
                  end
               end
               PARITY: begin
                  if (cnt == 4'd15) begin
                     par_err_pend <= (^shreg) ^ bit_val ^ ~cfg_even;
                     state        <= STOP;
                  end
               end
               STOP: begin
                  if (cnt == 4'd9) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         if (commit) begin
            if (accept) begin
               rx_data     <= shreg;
               parity_err  <= par_err_pend;
               framing_err <= ~stop_val;
               rx_ready    <= 1'b1;
               if (rx_data_reg_rd) overflow <= 1'b0;
            end else begin
               overflow <= 1'b1;
            end
         end else if (rx_data_reg_rd) begin
            rx_ready    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;

   logic       PCLK;
   logic       PRESET;
   logic       rx_sample_pulse;
   logic       RX;
   logic       data_bits;
   logic       parity_en;
   logic       parity_odd0_even1;
   logic       rx_data_reg_rd;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       parity_err;
   logic       framing_err;
   logic       overflow;
   logic       rx_busy;

   typedef struct packed {
      logic [7:0] d;
      logic       b8;
      logic       pen;
      logic       even;
      logic       flip;
      logic       stopl;
      logic [7:0] ed;
      logic       epe;
      logic       efe;
   } vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   vec_t vecs [8];
   exp_t sbq [$];
   int   checks;
   int   failures;
   int   cyc;
   int   rise_cyc;
   int   last_start;
   int   lat;
   logic rdy_prev;

   uart_rx_deframer #(.SYNC_STAGES(2)) dut (
      .PCLK              (PCLK),
      .PRESET            (PRESET),
      .rx_sample_pulse   (rx_sample_pulse),
      .RX                (RX),
      .data_bits         (data_bits),
      .parity_en         (parity_en),
      .parity_odd0_even1 (parity_odd0_even1),
      .rx_data_reg_rd    (rx_data_reg_rd),
      .rx_data           (rx_data),
      .rx_ready          (rx_ready),
      .parity_err        (parity_err),
      .framing_err       (framing_err),
      .overflow          (overflow),
      .rx_busy           (rx_busy)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   // Cycle counter, 1-in-4 sample strobe and rx_ready rise timestamp.
   initial begin
      cyc             = 0;
      rise_cyc        = 0;
      rdy_prev        = 1'b0;
      rx_sample_pulse = 1'b0;
      forever begin
         @(posedge PCLK);
         #2;
         cyc++;
         rx_sample_pulse = (cyc % 4 == 0);
         if (rx_ready === 1'b1 && rdy_prev !== 1'b1) rise_cyc = cyc;
         rdy_prev = rx_ready;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic align();
      hold(1);
      while (cyc % 4 != 0) hold(1);
   endtask

   task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
      exp_t e;
      e.d  = d;
      e.pe = pe;
      e.fe = fe;
      sbq.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen,
                             input logic even, input logic flip, input logic stopl,
                             input int gap);
      logic [7:0] dm;
      logic       p;
      dm                = b8 ? d : {1'b0, d[6:0]};
      p                 = even ? ^dm : ~(^dm);
      if (flip) p       = ~p;
      data_bits         = b8;
      parity_en         = pen;
      parity_odd0_even1 = even;
      RX                = 1'b0;
      last_start        = cyc;
      hold(64);
      for (int i = 0; i < (b8 ? 8 : 7); i++) begin
         RX = dm[i];
         hold(64);
      end
      if (pen) begin
         RX = p;
         hold(64);
      end
      RX = ~stopl;
      hold(64);
      RX = 1'b1;
      hold(gap);
   endtask

   task automatic wait_pop(input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (rx_ready !== 1'b1 && n < 3000) begin
         hold(1);
         n++;
      end
      chk({tag, "_ready"}, rx_ready, 1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({tag, "_data"}, rx_data, e.d);
         chk({tag, "_perr"}, parity_err, e.pe);
         chk({tag, "_ferr"}, framing_err, e.fe);
      end else begin
         chk({tag, "_sb_nonempty"}, sbq.size(), 1);
      end
   endtask

   task automatic read_clear(input string tag, input logic [7:0] ed);
      rx_data_reg_rd = 1'b1;
      hold(1);
      rx_data_reg_rd = 1'b0;
      chk({tag, "_rd_ready"}, rx_ready, 0);
      chk({tag, "_rd_data"}, rx_data, ed);
      chk({tag, "_rd_perr"}, parity_err, 0);
      chk({tag, "_rd_ferr"}, framing_err, 0);
      chk({tag, "_rd_ovf"}, overflow, 0);
   endtask

   initial begin
      checks            = 0;
      failures          = 0;
      lat               = 0;
      last_start        = 0;
      PRESET            = 1'b1;
      RX                = 1'b1;
      rx_data_reg_rd    = 1'b0;
      data_bits         = 1'b1;
      parity_en         = 1'b0;
      parity_odd0_even1 = 1'b0;

      vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
      vecs[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
      vecs[2] = '{8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0};
      vecs[3] = '{8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b0};
      vecs[4] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1};
      vecs[5] = '{8'hC8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h48, 1'b0, 1'b0};
      vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};

      hold(4);
      chk("rst_data", rx_data, 0);
      chk("rst_ready", rx_ready, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_ferr", framing_err, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", rx_busy, 0);
      PRESET = 1'b0;
      hold(8);

      for (int i = 0; i < 8; i++) begin
         align();
         push_exp(vecs[i].ed, vecs[i].epe, vecs[i].efe);
         send_frame(vecs[i].d, vecs[i].b8, vecs[i].pen, vecs[i].even,
                    vecs[i].flip, vecs[i].stopl, 32);
         wait_pop($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_ovf", i), overflow, 0);
         if (i == 0) begin
            lat = rise_cyc - last_start;
            chk("latency_range", {31'd0, (lat >= 600 && lat <= 650)}, 1);
         end
         read_clear($sformatf("vec%0d", i), vecs[i].ed);
      end

      // Back-to-back frames without a read: first kept, second discarded.
      align();
      push_exp(8'h12, 1'b0, 1'b0);
      send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32);
      wait_pop("b2b");
      chk("b2b_ovf", overflow, 1);
      read_clear("b2b", 8'h12);

      // Read landing exactly on the commit edge of 0x7E while full and overflowed.
      align();
      push_exp(8'h12, 1'b0, 1'b0);
      send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32);
      wait_pop("pre_rc");
      chk("pre_rc_ovf", overflow, 1);
      align();
      push_exp(8'h7E, 1'b0, 1'b0);
      fork
         send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32);
         begin
            hold(lat - 1);
            rx_data_reg_rd = 1'b1;
            hold(1);
            rx_data_reg_rd = 1'b0;
         end
      join
      wait_pop("rc");
      chk("rc_ovf", overflow, 0);
      read_clear("rc", 8'h7E);

      // Short low glitch on an idle line is rejected as a false start.
      align();
      RX = 1'b0;
      hold(20);
      RX = 1'b1;
      hold(8);
      chk("glitch_busy", rx_busy, 1);
      hold(80);
      chk("glitch_idle", rx_busy, 0);
      chk("glitch_ready", rx_ready, 0);

      // Leave a flagged byte unread, then reset in the middle of a frame.
      align();
      push_exp(8'h99, 1'b0, 1'b1);
      send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32);
      wait_pop("brk");
      align();
      RX = 1'b0;
      hold(64);
      RX = 1'b1;
      hold(100);
      RX = 1'b0;
      hold(50);
      chk("mid_busy", rx_busy, 1);
      PRESET = 1'b1;
      hold(1);
      PRESET = 1'b0;
      RX     = 1'b1;
      chk("mrst_data", rx_data, 0);
      chk("mrst_ready", rx_ready, 0);
      chk("mrst_perr", parity_err, 0);
      chk("mrst_ferr", framing_err, 0);
      chk("mrst_ovf", overflow, 0);
      chk("mrst_busy", rx_busy, 0);
      hold(700);
      chk("mrst_no_commit", rx_ready, 0);
      chk("mrst_still_idle", rx_busy, 0);

      align();
      push_exp(8'hC3, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32);
      wait_pop("post_rst");
      chk("post_rst_ovf", overflow, 0);
      read_clear("post_rst", 8'hC3);

      chk("sb_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
